sram_ctrl: RTL and testbench

- Sequences the pipeline MEM stage's word load/store requests onto the external 32-bit SRAM: one request in flight at a time.
- Translates the ARM byte address into the SRAM word address.
- Holds the bus stable for a fixed number of wait cycles to cover the SRAM access delay.
- Drops ready while busy so the hazard/freeze logic stalls the pipeline.
- Sits between the MEM stage and the SRAM pins.

---
 rtl/sram_ctrl_if.sv | 20 ++
 rtl/sram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// MEM-stage side of the SRAM controller: load/store request, address,
// store data, load result and the ready/stall indication.
interface sram_ctrl_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output rd_en, wr_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  rd_en, wr_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences single word loads/stores from the MEM stage onto an
// external 32-bit SRAM. One access in flight; bus held WAIT_CYCLES cycles;
// ready drops while busy so the pipeline freezes.
// Optional feature macro: SRAM_CTRL_LAST_READ_EN (one-entry last-read buffer
// that lets a repeated read of the same word complete without an SRAM cycle).
module sram_ctrl #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 5,
   parameter int CNT_W       = 4
) (
   input  logic         clk,
   input  logic         rst,
   sram_ctrl_if.slave   mem,
   output logic [16:0]  sram_address,
   output logic         sram_we_n,
   inout  wire  [31:0]  sram_dq
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [31:0]      LP_BASE = 32'(BASE_ADDR);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [16:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_we_n;
   logic              r_dq_oe;
   logic [16:0]       w_mapped;
   logic              w_last;
   logic              w_hit;
   logic [31:0]       w_buf_data;
   logic              w_ready;

   // Unsigned byte-to-word mapping; out-of-range addresses wrap silently.
   assign w_mapped = 17'((mem.address - LP_BASE) >> 2);
   assign w_last   = (r_cnt == LP_LAST);

`ifdef SRAM_CTRL_LAST_READ_EN
   logic        r_buf_valid;
   logic [16:0] r_buf_addr;
   logic [31:0] r_buf_data;

   assign w_hit      = r_buf_valid && (r_buf_addr == w_mapped);
   assign w_buf_data = r_buf_data;

   // Last-read buffer: any write invalidates it, each SRAM read refills it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf_valid <= 1'b0;
         r_buf_addr  <= 17'd0;
         r_buf_data  <= 32'd0;
      end else if (r_state == S_IDLE && w_next == S_WRITE) begin
         r_buf_valid <= 1'b0;
      end else if (r_state == S_READ && w_last) begin
         r_buf_valid <= 1'b1;
         r_buf_addr  <= r_addr;
         r_buf_data  <= sram_dq;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_buf_data = 32'd0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: writes win over reads; requests only sampled in IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (mem.wr_en) begin
               w_next = S_WRITE;
            end else if (mem.rd_en) begin
               w_next = w_hit ? S_DONE : S_READ;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_READ, S_WRITE: begin
            if (w_last) begin
               w_next = S_DONE;
            end else begin
               w_next = r_state;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic: ready follows the request in IDLE, high in DONE, low while busy.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_IDLE:  w_ready = ~(mem.rd_en | mem.wr_en);
         S_DONE:  w_ready = 1'b1;
         default: w_ready = 1'b0;
      endcase
   end

   // Datapath: latch address/data at request, run the wait counter, capture loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= {CNT_W{1'b0}};
         r_addr  <= 17'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= {CNT_W{1'b0}};
               if (w_next == S_READ || w_next == S_WRITE) begin
                  r_addr  <= w_mapped;
                  r_wdata <= mem.write_data;
               end
               if (w_next == S_DONE) begin
                  r_rdata <= w_buf_data;
               end
            end
            S_READ: begin
               r_cnt <= r_cnt + LP_ONE;
               if (w_last) begin
                  r_rdata <= sram_dq;
               end
            end
            S_WRITE: r_cnt <= r_cnt + LP_ONE;
            default: r_cnt <= {CNT_W{1'b0}};
         endcase
      end
   end

   // SRAM strobes registered from the next state so they cover exactly the WRITE cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we_n  <= 1'b1;
         r_dq_oe <= 1'b0;
      end else begin
         r_we_n  <= (w_next != S_WRITE);
         r_dq_oe <= (w_next == S_WRITE);
      end
   end

   assign mem.ready     = w_ready;
   assign mem.read_data = r_rdata;
   assign sram_address  = r_addr;
   assign sram_we_n     = r_we_n;
   assign sram_dq       = r_dq_oe ? r_wdata : {32{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural SRAM and a scoreboard
// of expected access results.
module tb_sram_ctrl;

   typedef struct {
      int          lat;
      int          we_cyc;
      logic [16:0] addr;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [16:0] sram_address;
   logic        sram_we_n;
   wire  [31:0] sram_dq;
   logic        m_drive = 1'b0;
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [16:0] last_addr = 17'd0;
   logic [31:0] last_rd   = 32'd0;
`ifdef SRAM_CTRL_LAST_READ_EN
   logic        mb_valid = 1'b0;
   logic [16:0] mb_addr  = 17'd0;
`endif
   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   sram_ctrl_if bus();

   sram_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .mem          (bus),
      .sram_address (sram_address),
      .sram_we_n    (sram_we_n),
      .sram_dq      (sram_dq)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: drives the bus only while the bench marks a read.
   assign sram_dq = (sram_we_n && m_drive) ? mem[sram_address[7:0]] : {32{1'bz}};
   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_address[7:0]] <= sram_dq;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] map_addr(input logic [31:0] a);
      logic [31:0] t;
      t = (a - 32'd1024) >> 2;
      return t[16:0];
   endfunction

   task automatic push_exp(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
      exp_t        e;
      logic [16:0] wa;
      logic        hit;
      wa  = map_addr(a);
      hit = 1'b0;
`ifdef SRAM_CTRL_LAST_READ_EN
      hit = rd && !wr && mb_valid && (mb_addr == wa);
`endif
      e.lat    = hit ? 1 : 6;
      e.we_cyc = wr ? 5 : 0;
      if (wr) begin
         ref_mem[wa[7:0]] = d;
         last_addr = wa;
`ifdef SRAM_CTRL_LAST_READ_EN
         mb_valid = 1'b0;
`endif
      end else begin
         if (!hit) begin
            last_addr = wa;
`ifdef SRAM_CTRL_LAST_READ_EN
            mb_valid = 1'b1;
            mb_addr  = wa;
`endif
         end
         last_rd = ref_mem[wa[7:0]];
      end
      e.addr  = last_addr;
      e.rdata = last_rd;
      sb.push_back(e);
   endtask

   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit toggle);
      exp_t e;
      int   cyc;
      int   we_cnt;
      bit   done;
      @(posedge clk); #1;
      bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = d;
      m_drive = rd && !wr;
      push_exp(rd, wr, a, d);
      cyc = 0; we_cnt = 0; done = 1'b0;
      @(negedge clk);
      check("req_ready_low", 32'(bus.ready), 32'd0);
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (toggle && cyc == 2) begin
            bus.address = ~a; bus.write_data = ~d;
         end
         @(negedge clk);
         if (!sram_we_n) begin
            we_cnt++;
            check("we_addr", 32'(sram_address), 32'(sb[0].addr));
         end
         if (bus.ready) done = 1'b1;
      end
      bus.rd_en = 1'b0; bus.wr_en = 1'b0; m_drive = 1'b0;
      if (!done) begin
         check("timeout", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("latency", 32'(cyc), 32'(e.lat));
         check("we_cycles", 32'(we_cnt), 32'(e.we_cyc));
         check("read_data", bus.read_data, e.rdata);
         check("sram_addr", 32'(sram_address), 32'(e.addr));
      end
   endtask

   initial begin
      exp_t e;
      int   t[2];
      int   n;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      bus.address = 32'd0; bus.write_data = 32'd0;
      #12;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_rdata", bus.read_data, 32'd0);
      check("rst_addr", 32'(sram_address), 32'd0);
      @(negedge clk); rst = 1'b1;

      // Basic write then read of the base address.
      access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0);
      access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
      // Word mapping, low address bits ignored.
      access(1'b0, 1'b1, 32'd1032, 32'h1234_5678, 1'b0);
      access(1'b1, 1'b0, 32'd1035, 32'd0, 1'b0);
      // Simultaneous rd/wr performs the write; mid-access input changes ignored.
      access(1'b1, 1'b1, 32'd1036, 32'hA5A5_A5A5, 1'b1);
      access(1'b1, 1'b0, 32'd1036, 32'd0, 1'b0);
      access(1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D, 1'b0);

      // Asynchronous reset in the middle of a write.
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'h1111_2222;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b0; #1;
      check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
      check("mid_rst_ready", 32'(bus.ready), 32'd0);
      check("mid_rst_rdata", bus.read_data, 32'd0);
      check("mid_rst_addr", 32'(sram_address), 32'd0);
      bus.wr_en = 1'b0; #1;
      check("mid_rst_ready_idle", 32'(bus.ready), 32'd1);
      @(negedge clk); rst = 1'b1;
      last_addr = 17'd0; last_rd = 32'd0;
`ifdef SRAM_CTRL_LAST_READ_EN
      mb_valid = 1'b0;
`endif

      // Back-to-back reads with rd_en held high.
      @(posedge clk); #1;
      bus.rd_en = 1'b1; bus.address = 32'd1024; m_drive = 1'b1;
      push_exp(1'b1, 1'b0, 32'd1024, 32'd0);
      push_exp(1'b1, 1'b0, 32'd1028, 32'd0);
      n = 0; t[0] = 0; t[1] = 0;
      for (int c = 0; c < 40 && n < 2; c++) begin
         @(negedge clk);
         if (bus.ready) begin
            t[n] = c;
            e = sb.pop_front();
            check("b2b_data", bus.read_data, e.rdata);
            check("b2b_addr", 32'(sram_address), 32'(e.addr));
            n++;
            if (n == 1) begin
               bus.address = 32'd1028;
            end else begin
               bus.rd_en = 1'b0; m_drive = 1'b0;
            end
         end
      end
      bus.rd_en = 1'b0; m_drive = 1'b0;
      check("b2b_pulses", 32'(n), 32'd2);
      check("b2b_first", 32'(t[0]), 32'd6);
      check("b2b_gap", 32'(t[1] - t[0]), 32'd7);

      // Repeated read (buffer hit when enabled), then write invalidates.
      access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
      access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
      access(1'b0, 1'b1, 32'd1028, 32'h0BAD_F00D, 1'b0);
      access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
      access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
